// File: rtl/console_uart_tx.sv
// Byte FIFO plus 8N1 serializer (LSB first) for the core's character strobe.
// Overflow is sticky and never backpressures the core; all outputs are registered.
module console_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               out_en,
  input  logic [7:0]         out_data,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int TW    = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] LVL_FULL  = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic            tx_reg;
  logic            busy_reg;
  logic            overflow_reg;

  logic [7:0]      fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   level_reg;
  logic [PW-1:0]   wr_ptr_next;
  logic [PW-1:0]   rd_ptr_next;

  logic            last_tick;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            to_idle;

  assign last_tick  = (timer_reg == TICK_LAST);
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LVL_FULL);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted.
  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    to_idle     = 1'b0;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (!fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && last_tick)))
      pop = 1'b1;
    if (out_en && (!fifo_full || pop))
      push = 1'b1;
    if (!pop && ((state_reg == IDLE) || ((state_reg == STOP) && last_tick)))
      to_idle = 1'b1;
    if (push)
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= out_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= wr_ptr_next - rd_ptr_next;
      if (out_en && fifo_full && !pop)
        overflow_reg <= 1'b1;
    end
  end

  // tx is driven from the state held during the previous cycle, so the line
  // trails the state register by one clock while keeping every cell full width.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      busy_reg <= !(to_idle && (wr_ptr_next == rd_ptr_next));
      unique case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
            timer_reg <= '0;
            state_reg <= START;
          end
        end
        START: begin
          tx_reg <= 1'b0;
          if (last_tick) begin
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end else begin
            timer_reg <= timer_reg + TICK_ONE;
          end
        end
        DATA: begin
          tx_reg <= shift_reg[0];
          if (last_tick) begin
            timer_reg <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7)
              state_reg <= STOP;
            else
              bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            timer_reg <= timer_reg + TICK_ONE;
          end
        end
        STOP: begin
          tx_reg <= 1'b1;
          if (last_tick) begin
            timer_reg <= '0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            timer_reg <= timer_reg + TICK_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign overflow   = overflow_reg;
  assign fifo_level = level_reg;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx at 4 clocks per bit; a negedge monitor decodes tx frames.
module tb_console_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          out_en   = 1'b0;
  logic [7:0]    out_data = 8'h00;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [AW:0]   fifo_level;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0] rx_bytes [$];
  int         rx_start [$];
  bit         rx_ok    [$];

  console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .out_en     (out_en),
    .out_data   (out_data),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Frame decoder: start detected on a 1->0 transition, bits sampled mid-cell.
  int         mon_cnt = -1;
  logic       prev_tx = 1'b1;
  logic [7:0] mon_sh  = 8'h00;
  int         mon_s   = 0;
  bit         mon_sok = 1'b0;

  always @(negedge clock) begin
    prev_tx <= tx;
    if (!reset_n) begin
      mon_cnt <= -1;
    end else if (mon_cnt < 0) begin
      if (tx === 1'b0 && prev_tx === 1'b1) begin
        mon_cnt <= 1;
        mon_s   <= cyc;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 2)
        mon_sok <= (tx === 1'b0);
      if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 2) % 4) == 0)
        mon_sh[(mon_cnt - 6) / 4] <= tx;
      if (mon_cnt == 38) begin
        rx_bytes.push_back(mon_sh);
        rx_start.push_back(mon_s);
        rx_ok.push_back(mon_sok && (tx === 1'b1));
        mon_cnt <= -1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 100000", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, output int n);
    out_en   = 1'b1;
    out_data = b;
    step();
    n        = cyc;
    out_en   = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_frames(input int n, input int bound);
    int k = 0;
    while (rx_bytes.size() < n && k < bound) begin
      step();
      k++;
    end
    check("frames_arrived", rx_bytes.size(), n);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      step();
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_start.delete();
    rx_ok.delete();
  endtask

  initial begin
    int n;
    logic [9:0] frame;
    logic [7:0] exp_q [$];

    // Reset state
    reset_n = 1'b0;
    step();
    step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    reset_n = 1'b1;
    step();

    // Single byte 0x48: exact cell-by-cell waveform and busy release
    push(8'h48, n);
    check("s1_level_after_push", fifo_level, 1);
    check("s1_busy_after_push", busy, 1);
    check("s1_tx_idle_edge_n", tx, 1);
    step();
    check("s1_level_after_pop", fifo_level, 0);
    check("s1_tx_idle_edge_n1", tx, 1);
    step();
    frame = 10'b1_01001000_0;
    for (int e = 0; e < 40; e++) begin
      check($sformatf("s1_cell%0d_cyc%0d", e / 4, e), tx, frame[e / 4]);
      if (e == 38) check("s1_busy_last_stop", busy, 1);
      if (e == 39) check("s1_busy_dropped", busy, 0);
      step();
    end
    check("s1_tx_idle_after", tx, 1);
    check("s1_level_end", fifo_level, 0);
    check("s1_nframes", rx_bytes.size(), 1);
    check("s1_byte", rx_bytes[0], 8'h48);
    check("s1_start_cycle", rx_start[0], n + 2);
    clear_rx();

    // Back-to-back 0x41, 0x42: 80 cycles, no idle gap
    out_en   = 1'b1;
    out_data = 8'h41;
    step();
    n        = cyc;
    out_data = 8'h42;
    step();
    out_en   = 1'b0;
    check("s2_level_two_queued", fifo_level, 1);
    wait_until(n + 80);
    check("s2_busy_end_frame2", busy, 1);
    step();
    check("s2_busy_dropped", busy, 0);
    wait_frames(2, 50);
    check("s2_byte0", rx_bytes[0], 8'h41);
    check("s2_byte1", rx_bytes[1], 8'h42);
    check("s2_start0", rx_start[0], n + 2);
    check("s2_gapless", rx_start[1] - rx_start[0], 40);
    check("s2_ok0", rx_ok[0], 1);
    check("s2_ok1", rx_ok[1], 1);
    clear_rx();

    // 18 consecutive strobes: byte 17 dropped, overflow sticky
    for (int i = 0; i < 18; i++) begin
      out_en   = 1'b1;
      out_data = 8'(i);
      step();
      if (i == 0) n = cyc;
      if (i == 16) begin
        check("s3_level_peak", fifo_level, 16);
        check("s3_no_overflow_yet", overflow, 0);
      end
      if (i == 17) begin
        check("s3_level_full_drop", fifo_level, 16);
        check("s3_overflow_set", overflow, 1);
      end
    end
    out_en = 1'b0;
    wait_idle(17 * 40 + 100);
    check("s3_nframes", rx_bytes.size(), 17);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("s3_byte%0d", i), rx_bytes[i], i);
      check($sformatf("s3_ok%0d", i), rx_ok[i], 1);
      if (i > 0) check($sformatf("s3_spacing%0d", i), rx_start[i] - rx_start[i-1], 40);
    end
    check("s3_overflow_sticky", overflow, 1);
    check("s3_level_end", fifo_level, 0);

    reset_n = 1'b0;
    #1;
    check("s3_reset_clears_overflow", overflow, 0);
    step();
    reset_n = 1'b1;
    step();
    clear_rx();

    // FIFO full; strobe lands on the STOP->START pop edge and is accepted
    for (int i = 0; i < 17; i++) begin
      out_en   = 1'b1;
      out_data = 8'h80 + 8'(i);
      step();
      if (i == 0) n = cyc;
    end
    out_en = 1'b0;
    check("s4_level_full", fifo_level, 16);
    wait_until(n + 40);
    check("s4_level_before_pop", fifo_level, 16);
    out_en   = 1'b1;
    out_data = 8'hEE;
    step();
    out_en   = 1'b0;
    check("s4_level_stays_full", fifo_level, 16);
    check("s4_overflow_stays_clear", overflow, 0);
    step();
    check("s4_next_start_bit", tx, 0);
    wait_idle(18 * 40 + 100);
    check("s4_nframes", rx_bytes.size(), 18);
    for (int i = 0; i < 18; i++)
      check($sformatf("s4_byte%0d", i), rx_bytes[i], (i < 17) ? (8'h80 + i) : 8'hEE);
    check("s4_overflow_end", overflow, 0);
    clear_rx();

    // 20 bytes in bursts with gaps; pointers run past both wrap points
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'((i * 37 + 5) & 8'hFF));
      push(exp_q[i], n);
      if ((i % 4) == 3) repeat (60) step();
    end
    wait_idle(20 * 40 + 100);
    check("s6_nframes", rx_bytes.size(), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("s6_byte%0d", i), rx_bytes[i], exp_q[i]);
    check("s6_no_overflow", overflow, 0);
    clear_rx();

    // Reset mid-DATA with three bytes queued
    out_en   = 1'b1;
    out_data = 8'h11;
    step();
    n        = cyc;
    out_data = 8'h22;
    step();
    out_data = 8'h33;
    step();
    out_data = 8'h44;
    step();
    out_en   = 1'b0;
    wait_until(n + 15);
    check("s5_tx_mid_data", tx, 0);
    check("s5_level_queued", fifo_level, 3);
    reset_n = 1'b0;
    #1;
    check("s5_rst_tx", tx, 1);
    check("s5_rst_level", fifo_level, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_overflow", overflow, 0);
    step();
    step();
    reset_n = 1'b1;
    clear_rx();
    repeat (50) step();
    check("s5_no_stale_frames", rx_bytes.size(), 0);
    check("s5_idle_tx", tx, 1);
    push(8'h5A, n);
    wait_frames(1, 100);
    check("s5_byte_after_reset", rx_bytes[0], 8'h5A);
    check("s5_start_after_reset", rx_start[0], n + 2);
    check("s5_frame_ok", rx_ok[0], 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
